// File: rtl/operand_entry_if.sv
// Display-side bus of the 4-bit signed adder lab front end.
// The master (operand_entry) takes the raw switches and key and produces the
// captured operands, the result and the FSM state for the seven-segment block.
interface operand_entry_if;
  logic [3:0] sw;
  logic       key_n;
  logic [3:0] input1;
  logic [3:0] input2;
  logic [3:0] sum;
  logic       overflow;
  logic [1:0] state;
  logic       result_valid;

  modport master (
    input  sw,
    input  key_n,
    output input1,
    output input2,
    output sum,
    output overflow,
    output state,
    output result_valid
  );

  modport slave (
    output sw,
    output key_n,
    input  input1,
    input  input2,
    input  sum,
    input  overflow,
    input  state,
    input  result_valid
  );
endinterface

// File: rtl/operand_entry.sv
// operand_entry: operand capture and 4-bit signed add for the adder lab.
// Switches and the enter key are synchronized, the key is (optionally)
// debounced, and a falling edge of the clean key level steps the FSM
// A -> B -> CALC -> SHOW -> A.
// Optional feature macro: OPERAND_ENTRY_DEBOUNCE_EN (debounce counter present).
// Without it the clean key level is simply the synchronized key.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           reset_n,
  operand_entry_if.master bus
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CALC = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  logic [3:0]        r_sw_s1;
  logic [3:0]        r_sw_s2;
  logic              r_key_s1;
  logic              r_key_s2;
  logic              w_level;
  logic              r_level_d;
  logic              r_enter;
  state_t            r_state;
  logic signed [3:0] r_in1;
  logic signed [3:0] r_in2;
  logic signed [3:0] r_sum;
  logic              r_ovf;
  logic              r_rv;
  logic signed [3:0] w_sum;

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic logic f_add_ovf(input logic signed [3:0] a,
                                     input logic signed [3:0] b,
                                     input logic signed [3:0] s);
    return (a[3] == b[3]) && (s[3] != a[3]);
  endfunction

  // Two-flop synchronizers; the key idles released (high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_s1  <= 4'b0000;
      r_sw_s2  <= 4'b0000;
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
    end else begin
      r_sw_s1  <= bus.sw;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= bus.key_n;
      r_key_s2 <= r_key_s1;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Accept a new key level only after it has differed from the clean level
  // for DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (r_key_s2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_level <= r_key_s2;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES == 0);
  assign w_level      = r_key_s2;
`endif

  // Registered press detector: one pulse on the 1->0 edge of the clean level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level_d <= 1'b1;
      r_enter   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_enter   <= r_level_d & ~w_level;
    end
  end

  assign w_sum = r_in1 + r_in2;

  // Entry sequencer with registered operand/result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_A;
      r_in1   <= '0;
      r_in2   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_rv    <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      case (r_state)
        S_A: begin
          if (r_enter) begin
            r_in1   <= $signed(r_sw_s2);
            r_state <= S_B;
          end
        end
        S_B: begin
          if (r_enter) begin
            r_in2   <= $signed(r_sw_s2);
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum   <= w_sum;
          r_ovf   <= f_add_ovf(r_in1, r_in2, w_sum);
          r_rv    <= 1'b1;
          r_state <= S_SHOW;
        end
        S_SHOW: begin
          if (r_enter) begin
            r_in1   <= '0;
            r_in2   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_A;
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign bus.input1       = r_in1;
  assign bus.input2       = r_in2;
  assign bus.sum          = r_sum;
  assign bus.overflow     = r_ovf;
  assign bus.state        = r_state;
  assign bus.result_valid = r_rv;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: vector table of additions plus hand
// sequences for reset mid-entry, key glitches, key hold and switch timing.
module tb_operand_entry;

  localparam int DEB = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  operand_entry_if bus ();

  operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full press: settle switches, hold key long enough, release and settle.
  task automatic press(input logic [3:0] v);
    bus.sw = v;
    tick(3);
    bus.key_n = 1'b0;
    tick(LAT + 3);
    bus.key_n = 1'b1;
    tick(LAT + 3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, int'(bus.state), 0);
    chk({tag, ".input1"}, int'(bus.input1), 0);
    chk({tag, ".input2"}, int'(bus.input2), 0);
    chk({tag, ".sum"}, int'(bus.sum), 0);
    chk({tag, ".overflow"}, int'(bus.overflow), 0);
    chk({tag, ".result_valid"}, int'(bus.result_valid), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{4'b0011, 4'b0010, 4'b0101, 1'b0};
    vecs[1] = '{4'b0111, 4'b0001, 4'b1000, 1'b1};
    vecs[2] = '{4'b1000, 4'b1111, 4'b0111, 1'b1};
    vecs[3] = '{4'b1111, 4'b0001, 4'b0000, 1'b0};
    vecs[4] = '{4'b1000, 4'b1000, 4'b0000, 1'b1};
    vecs[5] = '{4'b0101, 4'b1101, 4'b0010, 1'b0};
    vecs[6] = '{4'b0100, 4'b0100, 4'b1000, 1'b1};
    vecs[7] = '{4'b1001, 4'b0110, 4'b1111, 1'b0};

    bus.sw    = 4'b0000;
    bus.key_n = 1'b1;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk_zero("reset");
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Reset asserted mid-entry, then the next press lands in input1.
    press(4'b0101);
    chk("mid.state_b", int'(bus.state), 1);
    chk("mid.input1", int'(bus.input1), 5);
    reset_n = 1'b0;
    #2;
    chk_zero("mid_reset");
    tick(2);
    reset_n = 1'b1;
    tick(2);
    press(4'b1010);
    chk("mid.after_state", int'(bus.state), 1);
    chk("mid.after_input1", int'(bus.input1), 10);
    press(4'b0000);
    tick(2);
    press(4'b0000);
    chk_zero("mid_clear");

    // Table of additions, each with cycle-exact result pulse and clear.
    for (int k = 0; k < 8; k++) begin
      chk("vec.start_state", int'(bus.state), 0);
      press(vecs[k].a);
      chk("vec.state_b", int'(bus.state), 1);
      chk("vec.input1", int'(bus.input1), int'(vecs[k].a));
      bus.sw = vecs[k].b;
      tick(3);
      bus.key_n = 1'b0;
      tick(LAT);
      chk("vec.pre_enter_state", int'(bus.state), 1);
      tick(1);
      chk("vec.calc_state", int'(bus.state), 2);
      chk("vec.input2", int'(bus.input2), int'(vecs[k].b));
      chk("vec.calc_rv", int'(bus.result_valid), 0);
      tick(1);
      chk("vec.show_state", int'(bus.state), 3);
      chk("vec.rv_pulse", int'(bus.result_valid), 1);
      chk("vec.sum", int'(bus.sum), int'(vecs[k].s));
      chk("vec.overflow", int'(bus.overflow), int'(vecs[k].v));
      tick(1);
      chk("vec.rv_end", int'(bus.result_valid), 0);
      chk("vec.held_sum", int'(bus.sum), int'(vecs[k].s));
      bus.key_n = 1'b1;
      tick(LAT + 3);
      chk("vec.show_hold", int'(bus.state), 3);
      press(4'b1111);
      chk_zero("vec_clear");
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    // Short glitches never reach the FSM.
    for (int w = 1; w <= 3; w++) begin
      bus.key_n = 1'b0;
      tick(w);
      bus.key_n = 1'b1;
      tick(12);
      chk("glitch.state", int'(bus.state), 0);
    end
`else
    // Without debounce a 3-clock pulse is a valid press.
    bus.sw = 4'b0110;
    tick(3);
    bus.key_n = 1'b0;
    tick(3);
    bus.key_n = 1'b1;
    tick(8);
    chk("pulse3.state", int'(bus.state), 1);
    chk("pulse3.input1", int'(bus.input1), 6);
    press(4'b0001);
    tick(2);
    press(4'b0000);
    chk("pulse3.clear", int'(bus.state), 0);
`endif

    // 20-clock hold: one step exactly LAT clocks after the fall.
    bus.sw = 4'b0011;
    tick(3);
    bus.key_n = 1'b0;
    tick(LAT);
    chk("hold.before", int'(bus.state), 0);
    tick(1);
    chk("hold.step", int'(bus.state), 1);
    tick(20 - LAT - 1);
    chk("hold.single", int'(bus.state), 1);
    bus.key_n = 1'b1;
    tick(LAT + 4);
    chk("hold.release", int'(bus.state), 1);
    chk("hold.input1", int'(bus.input1), 3);

    // Switch change in the enter cycle: captured value is two cycles old.
    bus.sw = 4'b0100;
    tick(3);
    bus.key_n = 1'b0;
    tick(LAT - 1);
    bus.sw = 4'b1100;
    tick(2);
    chk("swlate.state", int'(bus.state), 2);
    chk("swlate.input2", int'(bus.input2), 4);
    tick(1);
    chk("swlate.sum", int'(bus.sum), 7);
    chk("swlate.overflow", int'(bus.overflow), 0);
    bus.key_n = 1'b1;
    tick(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
